// File: rtl/mbs_parametrizado_if.sv
// rtl/mbs_parametrizado_if.sv - start/busy/done handshake and operand/result bus of the shift-add multiplier
interface mbs_parametrizado_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicando;
    logic [WIDTH-1:0]     multiplicador;
    logic [2*WIDTH-1:0]   produto;
    logic                 busy;
    logic                 done;

    modport master (
        output start, signed_mode, multiplicando, multiplicador,
        input  produto, busy, done
    );

    modport slave (
        input  start, signed_mode, multiplicando, multiplicador,
        output produto, busy, done
    );
endinterface

// File: rtl/mbs_parametrizado.sv
// rtl/mbs_parametrizado.sv - parametrised signed/unsigned shift-add multiplier
// Optional early termination on zero multiplier: define MBS_EARLY_EXIT_EN.
module mbs_parametrizado #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    mbs_parametrizado_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {OCIOSO, CALC, FIM} estado_t;

    estado_t                estado_atual_q, estado_d;
    logic [2*WIDTH-1:0]     registrador_a_q, registrador_a_d;
    logic [WIDTH-1:0]       registrador_b_q, registrador_b_d;
    logic [2*WIDTH-1:0]     acumulador_q, acumulador_d;
    logic [CNT_W-1:0]       contador_q, contador_d;
    logic                   sinal_q, sinal_d;
    logic [2*WIDTH-1:0]     produto_q, produto_d;

    logic                   aceita;
    logic                   fim_calc;
    logic [WIDTH-1:0]       mag_a, mag_b, b_desloc;
    logic [2*WIDTH-1:0]     soma;

    assign aceita = bus.start && (estado_atual_q == OCIOSO || estado_atual_q == FIM);

    // Magnitudes: negating the most negative value yields 2^(WIDTH-1), still correct as unsigned.
    assign mag_a    = (bus.signed_mode && bus.multiplicando[WIDTH-1]) ? -bus.multiplicando : bus.multiplicando;
    assign mag_b    = (bus.signed_mode && bus.multiplicador[WIDTH-1]) ? -bus.multiplicador : bus.multiplicador;
    assign b_desloc = registrador_b_q >> 1;
    assign soma     = acumulador_q + (registrador_b_q[0] ? registrador_a_q : {2*WIDTH{1'b0}});

`ifdef MBS_EARLY_EXIT_EN
    assign fim_calc = (contador_q == ULTIMO) || (b_desloc == {WIDTH{1'b0}});
`else
    assign fim_calc = (contador_q == ULTIMO);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_atual_q <= OCIOSO;
        end else begin
            estado_atual_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_atual_q;
        case (estado_atual_q)
            OCIOSO:  if (bus.start) estado_d = CALC;
            CALC:    if (fim_calc) estado_d = FIM;
            FIM:     estado_d = bus.start ? CALC : OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        bus.busy    = (estado_atual_q == CALC);
        bus.done    = (estado_atual_q == FIM);
        bus.produto = produto_q;
    end

    always_comb begin
        registrador_a_d = registrador_a_q;
        registrador_b_d = registrador_b_q;
        acumulador_d    = acumulador_q;
        contador_d      = contador_q;
        sinal_d         = sinal_q;
        produto_d       = produto_q;
        if (aceita) begin
            registrador_a_d = {{WIDTH{1'b0}}, mag_a};
            registrador_b_d = mag_b;
            acumulador_d    = '0;
            contador_d      = '0;
            sinal_d         = bus.signed_mode & (bus.multiplicando[WIDTH-1] ^ bus.multiplicador[WIDTH-1]);
        end else if (estado_atual_q == CALC) begin
            acumulador_d    = soma;
            registrador_a_d = registrador_a_q << 1;
            registrador_b_d = b_desloc;
            contador_d      = contador_q + CNT_W'(1);
            // produto only moves here; intermediate sums stay in acumulador.
            if (fim_calc) begin
                produto_d = sinal_q ? -soma : soma;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            registrador_a_q <= '0;
            registrador_b_q <= '0;
            acumulador_q    <= '0;
            contador_q      <= '0;
            sinal_q         <= 1'b0;
            produto_q       <= '0;
        end else begin
            registrador_a_q <= registrador_a_d;
            registrador_b_q <= registrador_b_d;
            acumulador_q    <= acumulador_d;
            contador_q      <= contador_d;
            sinal_q         <= sinal_d;
            produto_q       <= produto_d;
        end
    end
endmodule

// File: tb/tb_mbs_parametrizado.sv
// tb/tb_mbs_parametrizado.sv - directed vector bench for mbs_parametrizado (WIDTH=8)
module tb_mbs_parametrizado;
    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    logic [15:0] prev_prod;

    mbs_parametrizado_if #(.WIDTH(8)) bus ();

    mbs_parametrizado #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        string       nm;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int exp_lat(input logic sm, input logic [7:0] b);
`ifdef MBS_EARLY_EXIT_EN
        logic [7:0] m;
        int l;
        m = (sm && b[7]) ? 8'(-b) : b;
        l = 1;
        for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
        return l;
`else
        return 8;
`endif
    endfunction

    // Drives one start, then follows the operation to its done pulse.
    task automatic launch(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_prod, input bit noise, input string nm);
        int k;
        int busy_cnt;
        int lat;
        bus.signed_mode   = sm;
        bus.multiplicando = a;
        bus.multiplicador = b;
        bus.start         = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        lat       = exp_lat(sm, b);
        k         = 0;
        busy_cnt  = 0;
        chk({nm, " produto held"}, bus.produto, prev_prod);
        while (!bus.done && k < 40) begin
            if (bus.busy) busy_cnt++;
            if (noise && k >= 1 && k <= 3) begin
                bus.start = 1'b1; bus.signed_mode = 1'b0;
                bus.multiplicando = 8'd1; bus.multiplicador = 8'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock);
            #1;
            k++;
        end
        bus.start = 1'b0;
        chk({nm, " done seen"}, bus.done, 1);
        chk({nm, " latency"}, k, lat);
        chk({nm, " busy cycles"}, busy_cnt, lat);
        chk({nm, " busy low at done"}, bus.busy, 0);
        chk({nm, " produto"}, bus.produto, exp_prod);
        prev_prod = exp_prod;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        pass_cnt  = 0;
        total_cnt = 0;
        prev_prod = 16'h0;
        vecs[0]  = '{1'b0, 8'd120, 8'd96,  16'h2D00, "u120x96"};
        vecs[1]  = '{1'b1, 8'hFD,  8'h05,  16'hFFF1, "s-3x5"};
        vecs[2]  = '{1'b1, 8'h80,  8'h80,  16'h4000, "s-128x-128"};
        vecs[3]  = '{1'b0, 8'hFF,  8'hFF,  16'hFE01, "u255x255"};
        vecs[4]  = '{1'b0, 8'd2,   8'd3,   16'h0006, "u2x3"};
        vecs[5]  = '{1'b1, 8'hFF,  8'hFF,  16'h0001, "s-1x-1"};
        vecs[6]  = '{1'b1, 8'h7F,  8'h80,  16'hC080, "s127x-128"};
        vecs[7]  = '{1'b0, 8'hFD,  8'h05,  16'h04F1, "u253x5"};
        vecs[8]  = '{1'b0, 8'h80,  8'h80,  16'h4000, "u128x128"};
        vecs[9]  = '{1'b1, 8'h07,  8'hFF,  16'hFFF9, "s7x-1"};
        vecs[10] = '{1'b0, 8'd120, 8'd1,   16'd120,  "u120x1"};
        vecs[11] = '{1'b0, 8'd120, 8'd0,   16'd0,    "u120x0"};
        vecs[12] = '{1'b1, 8'h80,  8'h01,  16'hFF80, "s-128x1"};
        vecs[13] = '{1'b0, 8'd0,   8'hFF,  16'd0,    "u0x255"};

        bus.start = 1'b0; bus.signed_mode = 1'b0;
        bus.multiplicando = 8'd0; bus.multiplicador = 8'd0;
        reset = 1'b1;
        #1;
        chk("reset produto", bus.produto, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Consecutive table entries are started in the previous done cycle.
        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].prod, 1'b0, vecs[i].nm);
        end
        @(posedge clock); #1;
        chk("done single pulse", bus.done, 0);
        chk("idle after table", bus.busy, 0);

        launch(1'b0, 8'd120, 8'd96, 16'h2D00, 1'b1, "ignore starts");
        @(posedge clock); #1;
        chk("no op from ignored start", bus.busy, 0);
        dn = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (bus.done) dn++;
        end
        chk("extra done pulses", dn, 0);
        chk("produto kept", bus.produto, 16'h2D00);

        launch(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, "b2b first");
        launch(1'b0, 8'd2,  8'd3,  16'h0006, 1'b0, "b2b second");

        @(negedge clock);
        bus.signed_mode = 1'b0; bus.multiplicando = 8'd200; bus.multiplicador = 8'd100;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("midop reset produto", bus.produto, 0);
        chk("midop reset busy", bus.busy, 0);
        chk("midop reset done", bus.done, 0);
        @(negedge clock);
        reset = 1'b0;
        prev_prod = 16'h0;
        launch(1'b0, 8'd7, 8'd6, 16'd42, 1'b0, "after reset");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
